// File: rtl/bus_initiator_if.sv
// Host-request, response and 8086-style bus signals of the bus initiator.
// The master modport is the initiator's view; slave is the host/responder view.
interface bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic        IOM;
    logic        RD;
    logic        WR;
    logic [19:0] Address;
    logic [7:0]  DOUT;
    logic        DOE;
    logic [7:0]  DIN;
    logic        READY;
    logic        busy;

    // Request handshake: a request transfers on a CLK edge where req_valid and
    // req_ready are both high; the host holds the request stable until then.
    modport master (
        input  req_valid, req_write, req_io, req_addr, req_wdata, DIN, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ALE, IOM, RD, WR, Address, DOUT, DOE, busy
    );

    modport slave (
        output req_valid, req_write, req_io, req_addr, req_wdata, DIN, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ALE, IOM, RD, WR, Address, DOUT, DOE, busy
    );
endinterface

// File: rtl/bus_initiator.sv
// Bus initiator: turns single-beat host requests into 8086-style T1-T4 bus
// cycles with READY-driven wait states and a wait-state timeout.
module bus_initiator #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            CLK,
    input  logic            RESET,
    bus_initiator_if.master bus,
    output logic [2:0]      dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state, state_d;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ale_q, ale_d;
    logic        iom_q, iom_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        doe_q, doe_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            write_q     <= 1'b0;
            wdata_q     <= 8'd0;
            ale_q       <= 1'b0;
            iom_q       <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            doe_q       <= 1'b0;
            addr_q      <= 20'd0;
            dout_q      <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_cnt_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ale_q       <= ale_d;
            iom_q       <= iom_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            doe_q       <= doe_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Outputs are computed for the state being entered, so every bus signal
    // comes straight from a flop.
    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        write_d     = write_q;
        wdata_d     = wdata_q;
        ale_d       = 1'b0;
        iom_d       = iom_q;
        addr_d      = addr_q;
        rd_d        = 1'b1;
        wr_d        = 1'b1;
        doe_d       = 1'b0;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_T1;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    iom_d   = bus.req_io;
                    addr_d  = bus.req_addr;
                    ale_d   = 1'b1;
                end
            end
            S_T1: begin
                state_d    = S_T2;
                wait_cnt_d = 8'd0;
                rd_d       = write_q;
                wr_d       = !write_q;
                doe_d      = write_q;
                if (write_q) dout_d = wdata_q;
            end
            S_T2: begin
                state_d = S_T3;
                rd_d    = rd_q;
                wr_d    = wr_q;
                doe_d   = doe_q;
            end
            S_T3, S_TW: begin
                // wait_cnt counts TW cycles already spent, so the abort comes
                // after MAX_WAIT+1 TW cycles and the counter never passes MAX_WAIT.
                if (bus.READY) begin
                    state_d     = S_T4;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 8'd0 : bus.DIN;
                end else if (state == S_TW && wait_cnt == WAIT_LIMIT) begin
                    state_d     = S_T4;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'd0;
                end else begin
                    state_d = S_TW;
                    rd_d    = rd_q;
                    wr_d    = wr_q;
                    doe_d   = doe_q;
                    if (state == S_TW) wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            S_T4: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.ALE       = ale_q;
    assign bus.IOM       = iom_q;
    assign bus.RD        = rd_q;
    assign bus.WR        = wr_q;
    assign bus.Address   = addr_q;
    assign bus.DOUT      = dout_q;
    assign bus.DOE       = doe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_state     = state;
endmodule
